// File: rtl/cpu_pkg.sv
// Shared types for the 8-bit CPU control path: opcodes, ALU encodings, sequencer states.
package cpu_pkg;

  localparam logic [3:0] OPC_ADD   = 4'd0;
  localparam logic [3:0] OPC_SUB   = 4'd1;
  localparam logic [3:0] OPC_AND   = 4'd2;
  localparam logic [3:0] OPC_OR    = 4'd3;
  localparam logic [3:0] OPC_LOAD  = 4'd4;
  localparam logic [3:0] OPC_STORE = 4'd5;
  localparam logic [3:0] OPC_JUMP  = 4'd6;
  localparam logic [3:0] OPC_HALT  = 4'hF;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } seq_state_t;

  function automatic logic is_alu_opc(input logic [3:0] opc);
    return opc < OPC_LOAD;
  endfunction

  function automatic logic [1:0] alu_sel(input logic [3:0] opc);
    logic [1:0] sel;
    case (opc)
      OPC_SUB: sel = ALU_SUB;
      OPC_AND: sel = ALU_AND;
      OPC_OR:  sel = ALU_OR;
      default: sel = ALU_ADD;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Sequencer <-> memory/datapath bundle; master is the sequencer, slave is memory + datapath.
interface cpu_sequencer_if;
  logic       run;
  logic [7:0] instr;
  logic       mem_ack;
  logic       fetch_req;
  logic       ir_load;
  logic       pc_inc;
  logic       pc_load;
  logic       reg_write;
  logic       mem_read;
  logic       mem_write;
  logic [1:0] alu_op;
  logic       alu_src;
  logic       instr_done;
  logic       bus_err;
  logic [2:0] state;

  modport master (
    input  run, instr, mem_ack,
    output fetch_req, ir_load, pc_inc, pc_load, reg_write, mem_read, mem_write,
           alu_op, alu_src, instr_done, bus_err, state
  );

  modport slave (
    output run, instr, mem_ack,
    input  fetch_req, ir_load, pc_inc, pc_load, reg_write, mem_read, mem_write,
           alu_op, alu_src, instr_done, bus_err, state
  );
endinterface

// File: rtl/cpu_seq_wait_timer.sv
// Counts request cycles without ack; expired when the count reaches WAIT_MAX (0 = never).
module cpu_seq_wait_timer #(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);
  localparam int CNT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

  logic [CNT_W-1:0] cnt_q;

  // Saturates at all-ones so a disabled timer never wraps back into range.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign expired = (WAIT_MAX != 0) && (cnt_q == CNT_W'(WAIT_MAX));
endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/exec/mem/wb sequencer; requests hold until mem_ack or WAIT_MAX timeout.
// CPU_SEQ_HALT_EN: opcode 4'hF parks the FSM in HALT until reset; otherwise 4'hF is a NOP.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int WAIT_MAX = 15,
  parameter int OPC_W    = 4
) (
  input logic             clk,
  input logic             rst,
  cpu_sequencer_if.master bus
);
  seq_state_t       state_q;
  seq_state_t       next_fetch;
  logic [OPC_W-1:0] opcode_q;
  logic             bus_err_q;
  logic [3:0]       opc;
  logic             req_state;
  logic             wt_clr;
  logic             wt_inc;
  logic             wt_expired;
  logic             instr_unused;

  assign opc          = 4'(opcode_q);
  assign instr_unused = ^bus.instr[7-OPC_W:0];
  assign next_fetch   = bus.run ? S_FETCH : S_IDLE;

  // Every non-request state and every ack clears, so FETCH/MEM are always entered at zero.
  assign req_state = (state_q == S_FETCH) || (state_q == S_MEM);
  assign wt_clr    = !req_state || bus.mem_ack;
  assign wt_inc    = req_state && !bus.mem_ack;

  cpu_seq_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (wt_clr),
    .inc     (wt_inc),
    .expired (wt_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      opcode_q  <= '0;
      bus_err_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.run && !bus_err_q) state_q <= S_FETCH;
        end
        S_FETCH: begin
          if (bus.mem_ack) begin
            opcode_q <= bus.instr[7 -: OPC_W];
            state_q  <= S_DECODE;
          end else if (wt_expired) begin
            bus_err_q <= 1'b1;
            state_q   <= S_IDLE;
          end
        end
        S_DECODE: state_q <= S_EXEC;
        S_EXEC: begin
          if (is_alu_opc(opc)) begin
            state_q <= S_WB;
          end else if ((opc == OPC_LOAD) || (opc == OPC_STORE)) begin
            state_q <= S_MEM;
`ifdef CPU_SEQ_HALT_EN
          end else if (opc == OPC_HALT) begin
            state_q <= S_HALT;
`endif
          end else begin
            state_q <= next_fetch;
          end
        end
        S_MEM: begin
          if (bus.mem_ack) begin
            state_q <= (opc == OPC_LOAD) ? S_WB : next_fetch;
          end else if (wt_expired) begin
            bus_err_q <= 1'b1;
            state_q   <= S_IDLE;
          end
        end
        S_WB:    state_q <= next_fetch;
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Strobes are masked during reset so a request in flight drops in the reset cycle itself.
  always_comb begin
    bus.fetch_req  = 1'b0;
    bus.ir_load    = 1'b0;
    bus.pc_inc     = 1'b0;
    bus.pc_load    = 1'b0;
    bus.reg_write  = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.alu_op     = ALU_ADD;
    bus.alu_src    = 1'b0;
    bus.instr_done = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          bus.fetch_req = 1'b1;
          bus.ir_load   = bus.mem_ack;
        end
        S_EXEC: begin
          if (is_alu_opc(opc)) begin
            bus.alu_op = alu_sel(opc);
          end else if ((opc == OPC_LOAD) || (opc == OPC_STORE)) begin
            bus.alu_src = 1'b1;
          end else if (opc == OPC_JUMP) begin
            bus.pc_load    = 1'b1;
            bus.instr_done = 1'b1;
          end else begin
`ifdef CPU_SEQ_HALT_EN
            if (opc != OPC_HALT) begin
              bus.pc_inc     = 1'b1;
              bus.instr_done = 1'b1;
            end
`else
            bus.pc_inc     = 1'b1;
            bus.instr_done = 1'b1;
`endif
          end
        end
        S_MEM: begin
          bus.alu_src = 1'b1;
          if (opc == OPC_LOAD) begin
            bus.mem_read = 1'b1;
          end else begin
            bus.mem_write  = 1'b1;
            bus.pc_inc     = bus.mem_ack;
            bus.instr_done = bus.mem_ack;
          end
        end
        S_WB: begin
          bus.reg_write  = 1'b1;
          bus.pc_inc     = 1'b1;
          bus.instr_done = 1'b1;
          if (is_alu_opc(opc)) bus.alu_op = alu_sel(opc);
        end
        default: ;
      endcase
    end
  end

  assign bus.bus_err = bus_err_q && !rst;
  assign bus.state   = rst ? S_IDLE : state_q;
endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: bench acts as memory, checks per-instruction strobe tallies.
module tb_cpu_sequencer;
  logic clk = 1'b0;
  logic rst;

  cpu_sequencer_if bus();

  cpu_sequencer #(.WAIT_MAX(4), .OPC_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit at_neg = 1'b0;

  logic [47:0] seq;
  int cyc, n_fetch, n_ir, n_inc, n_ld, n_rw, n_mr, n_mw, n_src, n_done;
  logic [1:0] alu_ex, alu_wb;
  logic [2:0] post_st;
  int cnt_a, cnt_b;

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] strobes();
    return {bus.fetch_req, bus.ir_load, bus.pc_inc, bus.pc_load, bus.reg_write,
            bus.mem_read, bus.mem_write, bus.alu_op, bus.alu_src, bus.instr_done};
  endfunction

  function automatic logic [14:0] outs();
    return {strobes(), bus.bus_err, bus.state};
  endfunction

  task automatic nxt();
    if (!at_neg) @(negedge clk);
    at_neg = 1'b0;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      nxt();
      rst = 1'b1;
      bus.mem_ack = 1'b1;
      #1;
      chk("rst_outs", 48'(outs()), 48'd0);
    end
    nxt();
    rst = 1'b0;
    bus.mem_ack = 1'b0;
    #1;
    chk("rst_state", 48'(bus.state), 48'd0);
    chk("rst_buserr", 48'(bus.bus_err), 48'd0);
  endtask

  // Memory model: ack once a request has waited fdly (fetch) / mdly (data) cycles.
  task automatic exec_instr(input logic [7:0] ins, input int fdly, input int mdly,
                            input int max_cyc, input bit drop);
    int wc;
    logic [2:0] prev;
    bit started;
    seq = '0; cyc = 0; n_fetch = 0; n_ir = 0; n_inc = 0; n_ld = 0; n_rw = 0;
    n_mr = 0; n_mw = 0; n_src = 0; n_done = 0; alu_ex = 2'b00; alu_wb = 2'b00;
    wc = 0; prev = 3'd7; started = 1'b0;
    bus.instr = ins;
    for (int c = 0; c < max_cyc + 20; c++) begin
      nxt();
      if (drop && bus.state == 3'd4) bus.run = 1'b0;
      if (bus.state != prev) wc = 0;
      prev = bus.state;
      bus.mem_ack = (bus.fetch_req && wc >= fdly) ||
                    ((bus.mem_read || bus.mem_write) && wc >= mdly);
      #1;
      if (bus.state == 3'd0) begin
        if (started) break;
        continue;
      end
      started = 1'b1;
      cyc++;
      seq = {seq[44:0], bus.state};
      n_fetch += int'(bus.fetch_req);
      n_ir    += int'(bus.ir_load);
      n_inc   += int'(bus.pc_inc);
      n_ld    += int'(bus.pc_load);
      n_rw    += int'(bus.reg_write);
      n_mr    += int'(bus.mem_read);
      n_mw    += int'(bus.mem_write);
      n_src   += int'(bus.alu_src);
      n_done  += int'(bus.instr_done);
      if (bus.state == 3'd3) alu_ex = bus.alu_op;
      if (bus.reg_write) alu_wb = bus.alu_op;
      wc++;
      if (bus.instr_done || cyc >= max_cyc) break;
    end
    @(negedge clk);
    at_neg = 1'b1;
    bus.mem_ack = 1'b0;
    post_st = bus.state;
  endtask

  initial begin
    rst = 1'b1;
    bus.run = 1'b1;
    bus.instr = 8'h00;
    bus.mem_ack = 1'b0;
    do_reset(2);

    exec_instr(8'h05, 0, 0, 12, 1'b0);
    chk("add_seq", seq, 48'o1235);
    chk("add_cyc", 48'(cyc), 48'd4);
    chk("add_rw", 48'(n_rw), 48'd1);
    chk("add_inc", 48'(n_inc), 48'd1);
    chk("add_done", 48'(n_done), 48'd1);
    chk("add_ir", 48'(n_ir), 48'd1);
    chk("add_aluwb", 48'(alu_wb), 48'd0);
    chk("add_post", 48'(post_st), 48'd1);

    exec_instr(8'h17, 0, 0, 12, 1'b0);
    chk("sub_seq", seq, 48'o1235);
    chk("sub_aluex", 48'(alu_ex), 48'd1);
    chk("sub_aluwb", 48'(alu_wb), 48'd1);

    exec_instr(8'h20, 2, 0, 12, 1'b0);
    chk("and_seq", seq, 48'o111235);
    chk("and_fetch", 48'(n_fetch), 48'd3);
    chk("and_aluwb", 48'(alu_wb), 48'd2);

    exec_instr(8'h3C, 4, 0, 12, 1'b0);
    chk("or_ack_at_limit_seq", seq, 48'o11111235);
    chk("or_ack_at_limit_err", 48'(bus.bus_err), 48'd0);
    chk("or_aluex", 48'(alu_ex), 48'd3);

    exec_instr(8'h4A, 0, 2, 12, 1'b0);
    chk("load_seq", seq, 48'o1234445);
    chk("load_cyc", 48'(cyc), 48'd7);
    chk("load_mr", 48'(n_mr), 48'd3);
    chk("load_src", 48'(n_src), 48'd4);
    chk("load_rw", 48'(n_rw), 48'd1);
    chk("load_aluwb", 48'(alu_wb), 48'd0);

    exec_instr(8'h60, 0, 0, 12, 1'b0);
    chk("jump_seq", seq, 48'o123);
    chk("jump_ld", 48'(n_ld), 48'd1);
    chk("jump_inc", 48'(n_inc), 48'd0);
    chk("jump_post", 48'(post_st), 48'd1);

    exec_instr(8'h70, 0, 0, 12, 1'b0);
    chk("nop_seq", seq, 48'o123);
    chk("nop_inc", 48'(n_inc), 48'd1);
    chk("nop_ld", 48'(n_ld), 48'd0);

    exec_instr(8'h5F, 0, 1, 12, 1'b1);
    chk("store_seq", seq, 48'o12344);
    chk("store_mw", 48'(n_mw), 48'd2);
    chk("store_inc", 48'(n_inc), 48'd1);
    chk("store_done", 48'(n_done), 48'd1);
    chk("store_rw", 48'(n_rw), 48'd0);
    chk("store_post", 48'(post_st), 48'd0);
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 5; i++) begin
      nxt(); #1;
      cnt_a += int'(bus.fetch_req);
      cnt_b += int'(bus.state != 3'd0);
    end
    chk("store_idle_fetch", 48'(cnt_a), 48'd0);
    chk("store_idle_state", 48'(cnt_b), 48'd0);

    bus.run = 1'b1;
    exec_instr(8'hF0, 0, 0, 3, 1'b0);
`ifdef CPU_SEQ_HALT_EN
    chk("halt_done", 48'(n_done), 48'd0);
    chk("halt_inc", 48'(n_inc), 48'd0);
    chk("halt_post", 48'(post_st), 48'd6);
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 20; i++) begin
      nxt(); #1;
      cnt_a += int'(bus.state == 3'd6);
      cnt_b += int'(strobes() != '0);
    end
    chk("halt_state", 48'(cnt_a), 48'd20);
    chk("halt_strobes", 48'(cnt_b), 48'd0);
`else
    chk("f0_seq", seq, 48'o123);
    chk("f0_inc", 48'(n_inc), 48'd1);
    chk("f0_done", 48'(n_done), 48'd1);
    chk("f0_post", 48'(post_st), 48'd1);
`endif

    do_reset(1);
    exec_instr(8'h05, 100, 0, 12, 1'b0);
    chk("tmo_seq", seq, 48'o11111);
    chk("tmo_fetch", 48'(n_fetch), 48'd5);
    chk("tmo_ir", 48'(n_ir), 48'd0);
    chk("tmo_inc", 48'(n_inc + n_done), 48'd0);
    chk("tmo_post", 48'(post_st), 48'd0);
    chk("tmo_buserr", 48'(bus.bus_err), 48'd1);
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 10; i++) begin
      nxt(); #1;
      cnt_a += int'(bus.fetch_req);
      cnt_b += int'(bus.state != 3'd0);
    end
    chk("tmo_no_restart_fetch", 48'(cnt_a), 48'd0);
    chk("tmo_no_restart_state", 48'(cnt_b), 48'd0);
    chk("tmo_sticky", 48'(bus.bus_err), 48'd1);
    do_reset(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
